// File: rtl/cpu_types_pkg.sv
// Shared CPU/memory types: RAM handshake status and the memory controller FSM states.
package cpu_types_pkg;

    typedef enum logic [1:0] {
        FREE   = 2'b00,
        BUSY   = 2'b01,
        ACCESS = 2'b10,
        ERROR  = 2'b11
    } ramstate_t;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        ISERVE = 2'b01,
        DREAD  = 2'b10,
        DWRITE = 2'b11
    } memctrl_state_t;

endpackage

// File: rtl/cache_mem_ctrl_if.sv
// Cache-pair request/response signals plus the single-ported RAM bus, as seen by the memory controller.
interface cache_mem_ctrl_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);

    logic                     iREN;
    logic [ADDR_W-1:0]        iaddr;
    logic                     dREN;
    logic                     dWEN;
    logic [ADDR_W-1:0]        daddr;
    logic [DATA_W-1:0]        dstore;
    logic                     iwait;
    logic                     dwait;
    logic [DATA_W-1:0]        iload;
    logic [DATA_W-1:0]        dload;
    logic                     ramREN;
    logic                     ramWEN;
    logic [ADDR_W-1:0]        ramaddr;
    logic [DATA_W-1:0]        ramstore;
    logic [DATA_W-1:0]        ramload;
    cpu_types_pkg::ramstate_t ramstate;

    // slave is the controller; master is the cache pair plus RAM model driving it
    modport slave (
        input  iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
        output iwait, dwait, iload, dload, ramREN, ramWEN, ramaddr, ramstore
    );

    modport master (
        output iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
        input  iwait, dwait, iload, dload, ramREN, ramWEN, ramaddr, ramstore
    );

endinterface

// File: rtl/mem_stats.sv
// Completion and RAM-error counters; only built when MEMCTRL_STATS_EN is defined.
`ifdef MEMCTRL_STATS_EN
module mem_stats (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        icomp_i,
    input  logic        dcomp_i,
    input  logic        err_i,
    output logic [31:0] icount_o,
    output logic [31:0] dcount_o,
    output logic [31:0] errcount_o
);

    logic [31:0] icount_q, dcount_q, errcount_q;

    // free-running counters, wrap naturally at 2^32
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            icount_q   <= '0;
            dcount_q   <= '0;
            errcount_q <= '0;
        end else begin
            if (icomp_i) icount_q   <= icount_q + 32'd1;
            if (dcomp_i) dcount_q   <= dcount_q + 32'd1;
            if (err_i)   errcount_q <= errcount_q + 32'd1;
        end
    end

    assign icount_o   = icount_q;
    assign dcount_o   = dcount_q;
    assign errcount_o = errcount_q;

endmodule
`endif

// File: rtl/cache_mem_ctrl.sv
// Arbitrates icache/dcache requests onto one RAM port and returns load data on ACCESS.
// Optional statistics counters are enabled with MEMCTRL_STATS_EN.
module cache_mem_ctrl
    import cpu_types_pkg::*;
#(
    parameter int ADDR_W       = 32,
    parameter int DATA_W       = 32,
    parameter int STARVE_LIMIT = 4
) (
    input  logic            CLK,
    input  logic            nRST,
    cache_mem_ctrl_if.slave bus
`ifdef MEMCTRL_STATS_EN
    ,
    output logic [31:0]     icount,
    output logic [31:0]     dcount,
    output logic [31:0]     errcount
`endif
);

    localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
    localparam logic [CNT_W-1:0] STARVE_MAX = CNT_W'(STARVE_LIMIT);

    memctrl_state_t    state_q, state_d;
    logic [CNT_W-1:0]  starve_q, starve_d;
    logic              in_serve, req_live, comp, icomp, dcomp;
    logic [ADDR_W-1:0] addr_c;
    logic [DATA_W-1:0] load_c;

    assign load_c      = bus.ramload;
    assign bus.ramaddr = addr_c;

    // Enable of whichever requester owns the current serve state
    always_comb begin
        req_live = 1'b0;
        unique case (state_q)
            ISERVE:  req_live = bus.iREN;
            DREAD:   req_live = bus.dREN;
            DWRITE:  req_live = bus.dWEN;
            default: req_live = 1'b0;
        endcase
    end

    assign in_serve = (state_q != IDLE);
    assign comp     = in_serve && (bus.ramstate == ACCESS);
    assign icomp    = comp && (state_q == ISERVE);
    assign dcomp    = comp && ((state_q == DREAD) || (state_q == DWRITE));

    always_comb begin
        bus.iwait    = 1'b1;
        bus.dwait    = 1'b1;
        bus.iload    = '0;
        bus.dload    = '0;
        bus.ramREN   = 1'b0;
        bus.ramWEN   = 1'b0;
        bus.ramstore = '0;
        addr_c       = '0;
        unique case (state_q)
            ISERVE: begin
                bus.ramREN = 1'b1;
                addr_c     = bus.iaddr;
                if (comp) begin
                    bus.iwait = 1'b0;
                    bus.iload = load_c;
                end
            end
            DREAD: begin
                bus.ramREN = 1'b1;
                addr_c     = bus.daddr;
                if (comp) begin
                    bus.dwait = 1'b0;
                    bus.dload = load_c;
                end
            end
            DWRITE: begin
                bus.ramWEN   = 1'b1;
                addr_c       = bus.daddr;
                bus.ramstore = bus.dstore;
                if (comp) bus.dwait = 1'b0;
            end
            default: ;
        endcase
    end

    // dcache normally wins; a starved icache is forced through once the count saturates
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (bus.iREN && ((starve_q == STARVE_MAX) || !(bus.dREN || bus.dWEN)))
                    state_d = ISERVE;
                else if (bus.dWEN)
                    state_d = DWRITE;
                else if (bus.dREN)
                    state_d = DREAD;
            end
            default: begin
                if (comp || !req_live) state_d = IDLE;
            end
        endcase

        starve_d = starve_q;
        if (!bus.iREN || icomp)
            starve_d = '0;
        else if (dcomp && (starve_q != STARVE_MAX))
            starve_d = starve_q + 1'b1;
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q  <= IDLE;
            starve_q <= '0;
        end else begin
            state_q  <= state_d;
            starve_q <= starve_d;
        end
    end

`ifdef MEMCTRL_STATS_EN
    mem_stats u_stats (
        .clk_i      (CLK),
        .rst_ni     (nRST),
        .icomp_i    (icomp),
        .dcomp_i    (dcomp),
        .err_i      (in_serve && (bus.ramstate == ERROR)),
        .icount_o   (icount),
        .dcount_o   (dcount),
        .errcount_o (errcount)
    );
`endif

endmodule

// File: tb/tb_cache_mem_ctrl.sv
// Directed bench for cache_mem_ctrl with a scoreboard of expected completions and a latency-programmable RAM.
module tb_cache_mem_ctrl;
    import cpu_types_pkg::*;

    logic CLK = 1'b0;
    logic nRST;
    always #5 CLK = ~CLK;

    cache_mem_ctrl_if bus ();

`ifdef MEMCTRL_STATS_EN
    logic [31:0] icount, dcount, errcount;
`endif

    cache_mem_ctrl #(
        .ADDR_W       (32),
        .DATA_W       (32),
        .STARVE_LIMIT (4)
    ) dut (
        .CLK      (CLK),
        .nRST     (nRST),
        .bus      (bus)
`ifdef MEMCTRL_STATS_EN
        ,
        .icount   (icount),
        .dcount   (dcount),
        .errcount (errcount)
`endif
    );

    typedef struct {
        bit          is_i;
        bit          is_wr;
        logic [31:0] addr;
        logic [31:0] data;
    } exp_t;

    exp_t sb[$];
    int   checks   = 0;
    int   failures = 0;
    int   k;
    int   err_n;
    int   lat;

    // RAM contents are a fixed function of address
    function automatic logic [31:0] ram_word(input logic [31:0] a);
        if (a == 32'h40) return 32'hDEADBEEF;
        return {a[15:0], ~a[15:0]};
    endfunction

    // RAM model: err_n ERROR cycles, then lat BUSY cycles, then ACCESS
    always_comb begin
        if (!(bus.ramREN || bus.ramWEN)) bus.ramstate = FREE;
        else if (k < err_n)              bus.ramstate = ERROR;
        else if (k < err_n + lat)        bus.ramstate = BUSY;
        else                             bus.ramstate = ACCESS;
        bus.ramload = ram_word(bus.ramaddr);
    end

    always @(posedge CLK or negedge nRST) begin
        if (!nRST) k <= 0;
        else if ((bus.ramREN || bus.ramWEN) && bus.ramstate != ACCESS) k <= k + 1;
        else k <= 0;
    end

    task automatic tick();
        @(posedge CLK);
        #2;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic push(input bit is_i, input bit is_wr, input logic [31:0] addr, input logic [31:0] data);
        exp_t e;
        e.is_i  = is_i;
        e.is_wr = is_wr;
        e.addr  = addr;
        e.data  = data;
        sb.push_back(e);
    endtask

    // Waits (bounded) for a completion cycle and checks it against the scoreboard head
    task automatic await_done(input string tag, input int exp_lat);
        int   c    = 0;
        bit   done = 1'b0;
        exp_t e;
        while (!done && c < 20) begin
            tick();
            c++;
            if (bus.iwait === 1'b0 || bus.dwait === 1'b0) done = 1'b1;
        end
        chk({tag, "_done"}, 32'(done), 32'd1);
        if (!done) return;
        chk({tag, "_latency"}, 32'(c), 32'(exp_lat));
        chk({tag, "_sb_nonempty"}, 32'(sb.size() > 0), 32'd1);
        if (sb.size() == 0) return;
        e = sb.pop_front();
        chk({tag, "_iwait"}, 32'(bus.iwait), e.is_i ? 32'd0 : 32'd1);
        chk({tag, "_dwait"}, 32'(bus.dwait), e.is_i ? 32'd1 : 32'd0);
        chk({tag, "_ramaddr"}, bus.ramaddr, e.addr);
        if (e.is_wr) begin
            chk({tag, "_ramWEN"}, 32'(bus.ramWEN), 32'd1);
            chk({tag, "_ramREN"}, 32'(bus.ramREN), 32'd0);
            chk({tag, "_ramstore"}, bus.ramstore, e.data);
            chk({tag, "_dload"}, bus.dload, 32'd0);
        end else begin
            chk({tag, "_ramREN"}, 32'(bus.ramREN), 32'd1);
            chk({tag, "_ramWEN"}, 32'(bus.ramWEN), 32'd0);
            chk({tag, "_load"}, e.is_i ? bus.iload : bus.dload, e.data);
            chk({tag, "_other_load"}, e.is_i ? bus.dload : bus.iload, 32'd0);
        end
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_iwait"},    32'(bus.iwait),  32'd1);
        chk({tag, "_dwait"},    32'(bus.dwait),  32'd1);
        chk({tag, "_iload"},    bus.iload,       32'd0);
        chk({tag, "_dload"},    bus.dload,       32'd0);
        chk({tag, "_ramREN"},   32'(bus.ramREN), 32'd0);
        chk({tag, "_ramWEN"},   32'(bus.ramWEN), 32'd0);
        chk({tag, "_ramaddr"},  bus.ramaddr,     32'd0);
        chk({tag, "_ramstore"}, bus.ramstore,    32'd0);
    endtask

    initial begin
        nRST       = 1'b1;
        bus.iREN   = 1'b0;
        bus.iaddr  = '0;
        bus.dREN   = 1'b0;
        bus.dWEN   = 1'b0;
        bus.daddr  = '0;
        bus.dstore = '0;
        err_n      = 0;
        lat        = 0;
        #1 nRST = 1'b0;
        tick();
        tick();
        chk_reset_outputs("reset");
`ifdef MEMCTRL_STATS_EN
        chk("reset_icount", icount, 32'd0);
        chk("reset_dcount", dcount, 32'd0);
        chk("reset_errcount", errcount, 32'd0);
`endif
        nRST = 1'b1;
        tick();

        // 1: icache read, ACCESS on the second serve cycle
        lat = 1;
        bus.iaddr = 32'h40;
        bus.iREN  = 1'b1;
        push(1'b1, 1'b0, 32'h40, 32'hDEADBEEF);
        tick();
        chk("t1_serve_ramREN", 32'(bus.ramREN), 32'd1);
        chk("t1_serve_ramaddr", bus.ramaddr, 32'h40);
        chk("t1_serve_iwait", 32'(bus.iwait), 32'd1);
        await_done("t1", 1);
        tick();
        bus.iREN = 1'b0;
        tick();

        // 2: simultaneous icache read and dcache write; write wins, then an IDLE gap
        lat = 0;
        bus.iaddr  = 32'h44;
        bus.iREN   = 1'b1;
        bus.daddr  = 32'h80;
        bus.dstore = 32'h12345678;
        bus.dWEN   = 1'b1;
        push(1'b0, 1'b1, 32'h80, 32'h12345678);
        push(1'b1, 1'b0, 32'h44, ram_word(32'h44));
        await_done("t2_write", 1);
        tick();
        chk("t2_gap_ramREN", 32'(bus.ramREN), 32'd0);
        chk("t2_gap_ramWEN", 32'(bus.ramWEN), 32'd0);
        bus.dWEN = 1'b0;
        await_done("t2_iread", 1);
        tick();
        bus.iREN = 1'b0;
        tick();

        // 3: dcache reads hog the port; icache forced through after 4 grants
        bus.iaddr = 32'h100;
        bus.daddr = 32'h20;
        bus.iREN  = 1'b1;
        bus.dREN  = 1'b1;
        for (int i = 0; i < 4; i++) push(1'b0, 1'b0, 32'h20, ram_word(32'h20));
        push(1'b1, 1'b0, 32'h100, ram_word(32'h100));
        await_done("t3_d0", 1);
        await_done("t3_d1", 2);
        await_done("t3_d2", 2);
        await_done("t3_d3", 2);
        await_done("t3_i", 2);
        tick();
        bus.iREN = 1'b0;
        bus.dREN = 1'b0;
        tick();

        // 4: three ERROR cycles during a dcache read, then ACCESS
        err_n = 3;
        lat   = 0;
        bus.daddr = 32'h80;
        bus.dREN  = 1'b1;
        push(1'b0, 1'b0, 32'h80, ram_word(32'h80));
        await_done("t4", 4);
        tick();
        bus.dREN = 1'b0;
        err_n = 0;
        tick();

        // 5: dcache read abandoned after one serve cycle
        lat = 10;
        bus.daddr = 32'h10;
        bus.dREN  = 1'b1;
        tick();
        chk("t5_serve_ramREN", 32'(bus.ramREN), 32'd1);
        chk("t5_serve_dwait", 32'(bus.dwait), 32'd1);
        bus.dREN = 1'b0;
        tick();
        chk("t5_abort_ramREN", 32'(bus.ramREN), 32'd0);
        chk("t5_abort_dwait", 32'(bus.dwait), 32'd1);
        chk("t5_abort_ramaddr", bus.ramaddr, 32'd0);
        tick();
        chk("t5_idle_ramREN", 32'(bus.ramREN), 32'd0);
        chk("t5_sb_empty", 32'(sb.size()), 32'd0);
`ifdef MEMCTRL_STATS_EN
        chk("stats_icount", icount, 32'd3);
        chk("stats_dcount", dcount, 32'd6);
        chk("stats_errcount", errcount, 32'd3);
`endif

        // 6: asynchronous reset in the middle of a dcache write
        bus.daddr  = 32'h90;
        bus.dstore = 32'hCAFEF00D;
        bus.dWEN   = 1'b1;
        tick();
        chk("t6_serve_ramWEN", 32'(bus.ramWEN), 32'd1);
        chk("t6_serve_ramstore", bus.ramstore, 32'hCAFEF00D);
        nRST = 1'b0;
        #1;
        chk_reset_outputs("t6_rst");
`ifdef MEMCTRL_STATS_EN
        chk("t6_rst_icount", icount, 32'd0);
        chk("t6_rst_errcount", errcount, 32'd0);
`endif
        bus.dWEN = 1'b0;
        tick();
        nRST = 1'b1;
        tick();
        chk_reset_outputs("t6_post");

        // controller is back in IDLE with a cleared starve count
        lat = 0;
        bus.iaddr = 32'h40;
        bus.iREN  = 1'b1;
        push(1'b1, 1'b0, 32'h40, 32'hDEADBEEF);
        await_done("t6_after", 1);
        tick();
        bus.iREN = 1'b0;
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
